// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t     : request/wait state of the single-outstanding fetcher
//   fetch_wr_t        : one registered FIFO write (up to two instruction slots)
//   FETCH_ALIGN_MASK  : clears the low three bits to form an 8-byte aligned fetch address
//   RESET_PC_DEFAULT  : default first fetch PC after reset
package fetch_pkg;

    typedef enum logic {FETCH_REQ, FETCH_WAIT} fetch_state_t;

    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFF8;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic        en1;
        logic        en2;
        logic [31:0] data1;
        logic [31:0] addr1;
        logic [31:0] data2;
        logic [31:0] addr2;
    } fetch_wr_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// SRAM-like instruction cache bus.
//   inst_req     : request valid (fetcher -> cache)
//   inst_addr    : 8-byte aligned request address (fetcher -> cache)
//   inst_addr_ok : request accepted this cycle (cache -> fetcher)
//   inst_data_ok : response valid this cycle (cache -> fetcher)
//   inst_rdata   : [31:0] word at addr, [63:32] word at addr+4 (cache -> fetcher)
// master = fetch unit, slave = cache.
interface instruction_fetch_unit_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: writer side of the instruction FIFO.
// Generates fetch PCs, issues one aligned 64-bit cache request at a time, and
// splits each response into one or two (instruction, PC) FIFO writes that are
// presented one cycle after the response.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   redirect_valid/_pc       : branch/exception redirect (also flushes the FIFO)
//   fifo_full                : FIFO back-pressure, checked only at request time
//   ibus                     : cache bus (master side)
//   write_en1/2, write_data1/2, write_address1/2 : FIFO write port
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    input  logic                        fifo_full,
    instruction_fetch_unit_if.master    ibus,
    output logic                        write_en1,
    output logic                        write_en2,
    output logic [31:0]                 write_data1,
    output logic [31:0]                 write_address1,
    output logic [31:0]                 write_data2,
    output logic [31:0]                 write_address2
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         kill_q, kill_d;
    fetch_wr_t    wr_q, wr_d;

    logic         req;
    logic [31:0]  fetch_addr;
    fetch_wr_t    wr_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            kill_q   <= 1'b0;
            wr_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        wr_d       = '0;
        req        = 1'b0;
        fetch_addr = pc_q & FETCH_ALIGN_MASK;

        case (state_q)
            FETCH_REQ: begin
                // Holding off on redirect keeps the stale PC off the bus.
                req = !fifo_full && !redirect_valid;
                if (req && ibus.inst_addr_ok) begin
                    req_pc_d = pc_q;
                    pc_d     = fetch_addr + 32'd8;
                    state_d  = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (ibus.inst_data_ok) begin
                    state_d = FETCH_REQ;
                    kill_d  = 1'b0;
                    // Response splitter: a PC in the upper word of the pair
                    // yields only that word; otherwise both words are written.
                    if (!kill_q && !redirect_valid) begin
                        wr_d.en1   = 1'b1;
                        wr_d.addr1 = req_pc_q;
                        if (req_pc_q[2]) begin
                            wr_d.data1 = ibus.inst_rdata[63:32];
                        end else begin
                            wr_d.data1 = ibus.inst_rdata[31:0];
                            wr_d.en2   = 1'b1;
                            wr_d.data2 = ibus.inst_rdata[63:32];
                            wr_d.addr2 = req_pc_q + 32'd4;
                        end
                    end
                end else if (redirect_valid) begin
                    // Response still in flight: drop it when it arrives.
                    kill_d = 1'b1;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    // The FIFO is flushed in a redirect cycle, so a write presented then must not land.
    assign wr_out = redirect_valid ? '0 : wr_q;

    assign ibus.inst_req   = req;
    assign ibus.inst_addr  = fetch_addr;

    assign write_en1      = wr_out.en1;
    assign write_en2      = wr_out.en2;
    assign write_data1    = wr_out.data1;
    assign write_address1 = wr_out.addr1;
    assign write_data2    = wr_out.data2;
    assign write_address2 = wr_out.addr2;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a small cache responder, a
// transaction-level model of the fetch stream checked every cycle, and
// hand-computed literal checks at the points of interest.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fifo_full = 1'b0;
    logic        write_en1, write_en2;
    logic [31:0] write_data1, write_address1, write_data2, write_address2;

    instruction_fetch_unit_if ibus();

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_full      (fifo_full),
        .ibus           (ibus),
        .write_en1      (write_en1),
        .write_en2      (write_en2),
        .write_data1    (write_data1),
        .write_address1 (write_address1),
        .write_data2    (write_data2),
        .write_address2 (write_address2)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic chk_on = 1'b0;
    logic want_rst = 1'b1;

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // ---------------- cache responder ----------------
    int          dlat = 2;        // cycles from acceptance to data_ok
    logic        c_busy = 1'b0;
    int          c_cnt = 0;
    logic [31:0] c_addr = '0;
    logic [31:0] c_pend = '0;

    initial begin
        ibus.inst_addr_ok = 1'b0;
        ibus.inst_data_ok = 1'b0;
        ibus.inst_rdata   = '0;
    end

    initial forever begin
        @(posedge clk);
        if (rst) c_busy = 1'b0;
        else if (ibus.inst_data_ok) c_busy = 1'b0;
        else if (c_busy) c_cnt = c_cnt - 1;
        else if (ibus.inst_addr_ok) begin
            c_busy = 1'b1;
            c_cnt  = dlat - 1;
            c_addr = c_pend;
        end
    end

    // One clock cycle: drive inputs after the falling edge, let the cache answer,
    // return mid-cycle so literal checks can sample settled outputs.
    task automatic cyc(input logic r, input logic [31:0] rpc, input logic full);
        @(negedge clk);
        rst = want_rst;
        redirect_valid = r;
        redirect_pc = rpc;
        fifo_full = full;
        #1;
        ibus.inst_addr_ok = 1'b0;
        ibus.inst_data_ok = 1'b0;
        ibus.inst_rdata   = '0;
        if (!rst) begin
            if (c_busy) begin
                if (c_cnt == 0) begin
                    ibus.inst_data_ok = 1'b1;
                    ibus.inst_rdata   = {word(c_addr + 32'd4), word(c_addr)};
                end
            end else if (ibus.inst_req) begin
                ibus.inst_addr_ok = 1'b1;
                c_pend = ibus.inst_addr;
            end
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Step idle cycles until the next cycle carries data_ok.
    task automatic until_data();
        int n = 0;
        @(posedge clk); #1;
        while (!(c_busy && c_cnt == 0) && n < 20) begin
            cyc(1'b0, 32'h0, 1'b0);
            @(posedge clk); #1;
            n++;
        end
        chk("until_data_timeout", (n >= 20) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Hold fifo_full until no request is outstanding and any write has drained.
    task automatic drain();
        int n = 0;
        @(posedge clk); #1;
        while (c_busy && n < 20) begin
            cyc(1'b0, 32'h0, 1'b1);
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", (n >= 20) ? 32'd1 : 32'd0, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] m_pc;
    logic        m_busy, m_drop, m_wr;
    logic [31:0] m_req_pc, m_wpc;
    logic [63:0] m_wdat;

    initial forever begin
        logic        e_req, e_en1, e_en2;
        logic [31:0] e_d1, e_a1, e_d2, e_a2;
        logic [161:0] e_w, a_w;
        @(negedge clk);
        #3;
        if (rst) begin
            m_pc = 32'hBFC0_0000; m_busy = 1'b0; m_drop = 1'b0; m_wr = 1'b0;
            m_req_pc = '0; m_wpc = '0; m_wdat = '0;
        end else if (chk_on) begin
            e_req = !m_busy && !fifo_full && !redirect_valid;
            vectors++;
            if (ibus.inst_req !== e_req) begin
                miscompares++;
                $display("FAIL model_req: got %b expected %b (t=%0t)", ibus.inst_req, e_req, $time);
            end
            if (e_req) begin
                vectors++;
                if (ibus.inst_addr !== (m_pc & 32'hFFFF_FFF8)) begin
                    miscompares++;
                    $display("FAIL model_addr: got %h expected %h (t=%0t)",
                             ibus.inst_addr, m_pc & 32'hFFFF_FFF8, $time);
                end
            end
            e_en1 = 0; e_en2 = 0; e_d1 = '0; e_a1 = '0; e_d2 = '0; e_a2 = '0;
            if (m_wr && !redirect_valid) begin
                e_en1 = 1'b1;
                e_a1  = m_wpc;
                e_d1  = m_wpc[2] ? m_wdat[63:32] : m_wdat[31:0];
                if (!m_wpc[2]) begin
                    e_en2 = 1'b1;
                    e_d2  = m_wdat[63:32];
                    e_a2  = m_wpc + 32'd4;
                end
            end
            e_w = {e_en1, e_en2, e_d1, e_a1, e_d2, e_a2};
            a_w = {write_en1, write_en2, write_data1, write_address1, write_data2, write_address2};
            vectors++;
            if (a_w !== e_w) begin
                miscompares++;
                $display("FAIL model_write: got %h expected %h (t=%0t)", a_w, e_w, $time);
            end
            // advance the model by this cycle's events
            m_wr = 1'b0;
            if (m_busy && ibus.inst_data_ok) begin
                m_busy = 1'b0;
                if (!m_drop && !redirect_valid) begin
                    m_wr = 1'b1; m_wpc = m_req_pc; m_wdat = ibus.inst_rdata;
                end
                m_drop = 1'b0;
            end else if (m_busy && redirect_valid) begin
                m_drop = 1'b1;
            end else if (e_req && ibus.inst_addr_ok) begin
                m_busy = 1'b1;
                m_req_pc = m_pc;
                m_pc = (m_pc & 32'hFFFF_FFF8) + 32'd8;
            end
            if (redirect_valid) m_pc = redirect_pc;
        end
    end

    // ---------------- directed script ----------------
    logic [31:0] tbl_pc [5] = '{32'h8000_2004, 32'h8000_3000, 32'h8000_3104, 32'h0000_0010, 32'h9000_0ff8};

    initial begin
        // reset, first fetch, split of an even-word PC
        want_rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        want_rst = 1'b0;
        chk_on = 1'b1;
        dlat = 2;
        cyc(1'b0, 32'h0, 1'b0);
        chk("rst_we1", {31'd0, write_en1}, 32'd0);
        chk("rst_we2", {31'd0, write_en2}, 32'd0);
        chk("first_req", {31'd0, ibus.inst_req}, 32'd1);
        chk("first_addr", ibus.inst_addr, 32'hBFC0_0000);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t1_en1", {31'd0, write_en1}, 32'd1);
        chk("t1_en2", {31'd0, write_en2}, 32'd1);
        chk("t1_addr1", write_address1, 32'hBFC0_0000);
        chk("t1_addr2", write_address2, 32'hBFC0_0004);
        chk("t1_data1", write_data1, 32'hADF4_5678);
        chk("t1_data2", write_data2, 32'hADF4_567C);
        chk("t1_next_addr", ibus.inst_addr, 32'hBFC0_0008);

        // redirect to an odd-word PC: single write of the upper word
        drain();
        cyc(1'b1, 32'h8000_0104, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t2_req", {31'd0, ibus.inst_req}, 32'd1);
        chk("t2_addr", ibus.inst_addr, 32'h8000_0100);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        dlat = 3;
        cyc(1'b0, 32'h0, 1'b0);
        chk("t2_en1", {31'd0, write_en1}, 32'd1);
        chk("t2_en2", {31'd0, write_en2}, 32'd0);
        chk("t2_addr1", write_address1, 32'h8000_0104);
        chk("t2_data1", write_data1, 32'h9234_577C);
        chk("t2_next_addr", ibus.inst_addr, 32'h8000_0108);

        // redirect while waiting: the response is dropped
        cyc(1'b1, 32'h8000_1000, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        dlat = 2;
        cyc(1'b0, 32'h0, 1'b0);
        chk("t3_no_write", {31'd0, write_en1}, 32'd0);
        chk("t3_req", {31'd0, ibus.inst_req}, 32'd1);
        chk("t3_addr", ibus.inst_addr, 32'h8000_1000);

        // redirect coinciding with data_ok
        until_data();
        cyc(1'b1, 32'h8000_2000, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t4a_no_write", {31'd0, write_en1}, 32'd0);
        chk("t4a_addr", ibus.inst_addr, 32'h8000_2000);
        // redirect in the cycle the registered write is presented
        until_data();
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h8000_3000, 1'b0);
        chk("t4b_en1", {31'd0, write_en1}, 32'd0);
        chk("t4b_en2", {31'd0, write_en2}, 32'd0);
        chk("t4b_req", {31'd0, ibus.inst_req}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t4b_resume", ibus.inst_addr, 32'h8000_3000);

        // fifo_full held for five cycles in REQ
        until_data();
        cyc(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("t5_full_req", {31'd0, ibus.inst_req}, 32'd0);
        end
        cyc(1'b0, 32'h0, 1'b0);
        chk("t5_req", {31'd0, ibus.inst_req}, 32'd1);
        chk("t5_addr", ibus.inst_addr, 32'h8000_3008);

        // PC wrap-around
        drain();
        cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t6_addr", ibus.inst_addr, 32'hFFFF_FFF8);
        until_data();
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t6_addr2", write_address2, 32'hFFFF_FFFC);
        chk("t6_data2", write_data2, 32'hEDCB_A984);
        chk("t6_wrap_addr", ibus.inst_addr, 32'h0000_0000);
        until_data();
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t6_w_addr1", write_address1, 32'h0000_0000);
        chk("t6_w_addr2", write_address2, 32'h0000_0004);

        // reset with a request outstanding
        cyc(1'b0, 32'h0, 1'b0);
        want_rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        want_rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b0);
        chk("t7_req", {31'd0, ibus.inst_req}, 32'd1);
        chk("t7_addr", ibus.inst_addr, 32'hBFC0_0000);
        chk("t7_we1", {31'd0, write_en1}, 32'd0);

        // mixed back-pressure and redirect pattern, checked by the model only
        dlat = 1;
        for (int i = 0; i < 48; i++) begin
            logic r, f;
            logic [31:0] p;
            int k;
            if (i == 20) dlat = 3;
            f = (i % 7 == 3) || (i % 7 == 4);
            r = (i == 5) || (i == 13) || (i == 14) || (i == 22) || (i == 31);
            k = (i == 5) ? 0 : (i == 13) ? 1 : (i == 14) ? 2 : (i == 22) ? 3 : 4;
            p = r ? tbl_pc[k] : 32'h0;
            cyc(r, p, f);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected script end");
        $fatal(1, "watchdog");
    end

endmodule
